// File: rtl/if_id_queue_pkg.sv
// Types shared by the IF/ID queue and its storage array.
`include "if_id_defs.sv"

package if_id_queue_pkg;
    typedef struct packed {
        logic [`INSTR_LEN-1:0] instr;
        logic [`WORD-1:0]      pc;
    } entry_t;

    localparam entry_t NOP_ENTRY = '{instr: `NOP_INSTR, pc: '0};
endpackage

// File: rtl/if_id_defs.sv
// Shared datapath widths and the canonical NOP encoding for the fetch/decode boundary.
`ifndef IF_ID_DEFS_SV
`define IF_ID_DEFS_SV
`define WORD      32
`define INSTR_LEN 32
`define NOP_INSTR 32'h00000013
`endif

// File: rtl/if_id_queue_storage.sv
// if_id_storage: DEPTH-entry register file, one synchronous write port and one
// asynchronous read port.
`include "if_id_defs.sv"

module if_id_storage
    import if_id_queue_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  entry_t                   wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output entry_t                   rdata
);
    entry_t mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= wdata;
    end

    assign rdata = mem_q[raddr];
endmodule

// File: rtl/if_id_queue.sv
// IF/ID decoupling queue: DEPTH-entry FIFO between fetch and decode with branch flush.
// Define IF_ID_PERF_CNT_EN to add the 16-bit saturating stall_cnt output.
`include "if_id_defs.sv"

module if_id_queue
    import if_id_queue_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [`INSTR_LEN-1:0] in_instr,
    input  logic [`WORD-1:0]      in_pc,
    output logic                  in_ready,
    input  logic                  flush,
    output logic                  out_valid,
    output logic [`INSTR_LEN-1:0] out_instr,
    output logic [`WORD-1:0]      out_pc,
    input  logic                  out_ready
`ifdef IF_ID_PERF_CNT_EN
    ,
    output logic [15:0]           stall_cnt
`endif
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0] head_q, head_d, tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic          push, pop;
    entry_t        head_entry;

    // Handshakes derive only from registered count, so in_ready never sees out_ready.
    assign in_ready  = (count_q < CW'(DEPTH));
    assign out_valid = (count_q != '0);
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready && !flush;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push) tail_d = tail_q + PW'(1);
            if (pop)  head_d = head_q + PW'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    if_id_storage #(.DEPTH(DEPTH)) u_storage (
        .clk   (clk),
        .we    (push),
        .waddr (tail_q),
        .wdata ('{instr: in_instr, pc: in_pc}),
        .raddr (head_q),
        .rdata (head_entry)
    );

    assign out_instr = out_valid ? head_entry.instr : NOP_ENTRY.instr;
    assign out_pc    = out_valid ? head_entry.pc    : NOP_ENTRY.pc;

`ifdef IF_ID_PERF_CNT_EN
    logic [15:0] stall_cnt_q;

    always_ff @(posedge clk) begin
        if (reset)
            stall_cnt_q <= '0;
        else if (in_valid && !in_ready && stall_cnt_q != 16'hFFFF)
            stall_cnt_q <= stall_cnt_q + 16'd1;
    end

    assign stall_cnt = stall_cnt_q;
`endif
endmodule

// File: tb/tb_if_id_queue.sv
// Scoreboard bench for if_id_queue: driver appends accepted pushes to an expected
// FIFO, a monitor compares every cycle's outputs against it and retires handshakes.
module tb_if_id_queue;
    localparam int DEPTH = 2;
    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk = 1'b0;
    logic        reset, in_valid, flush, out_ready;
    logic [31:0] in_instr, in_pc;
    logic        in_ready, out_valid;
    logic [31:0] out_instr, out_pc;
`ifdef IF_ID_PERF_CNT_EN
    logic [15:0] stall_cnt;
    logic [15:0] stall_exp = 16'd0;
`endif

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } ent_t;

    ent_t exp_q[$];
    bit   chk_en = 1'b0;
    int   checks = 0;
    int   errors = 0;

    if_id_queue #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_instr  (in_instr),
        .in_pc     (in_pc),
        .in_ready  (in_ready),
        .flush     (flush),
        .out_valid (out_valid),
        .out_instr (out_instr),
        .out_pc    (out_pc),
        .out_ready (out_ready)
`ifdef IF_ID_PERF_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: outputs of the current cycle, sampled mid-low-phase.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (chk_en) begin
                chk("in_ready", 64'(in_ready), 64'(exp_q.size() < DEPTH));
                chk("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
                if (exp_q.size() != 0) begin
                    chk("out_instr", 64'(out_instr), 64'(exp_q[0].instr));
                    chk("out_pc", 64'(out_pc), 64'(exp_q[0].pc));
                    if (out_ready && !flush && !reset) void'(exp_q.pop_front());
                end else begin
                    chk("idle_instr", 64'(out_instr), 64'(NOP));
                    chk("idle_pc", 64'(out_pc), 64'd0);
                end
`ifdef IF_ID_PERF_CNT_EN
                chk("stall_cnt", 64'(stall_cnt), 64'(stall_exp));
`endif
            end
        end
    end

    // Driver: apply one cycle of inputs, then record the expected effect of the edge.
    task automatic cyc(input logic v, input logic [31:0] ins, input logic [31:0] p,
                       input logic fl, input logic ordy, input logic rst);
        bit room, acc;
        @(negedge clk);
        in_valid  = v;
        in_instr  = ins;
        in_pc     = p;
        flush     = fl;
        out_ready = ordy;
        reset     = rst;
        room = (exp_q.size() < DEPTH);
        acc  = v && !fl && !rst && room;
        #2;
        if (rst || fl) exp_q.delete();
        else if (acc) exp_q.push_back('{instr: ins, pc: p});
`ifdef IF_ID_PERF_CNT_EN
        if (rst) stall_exp = 16'd0;
        else if (v && !room && stall_exp != 16'hFFFF) stall_exp++;
`endif
        if (rst) chk_en = 1'b1;
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_instr = '0; in_pc = '0;
        flush = 1'b0; out_ready = 1'b0;
        cyc(0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 1);

        // Single push becomes visible the next cycle.
        cyc(1, 32'hA, 32'd4, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 1, 0);

        // Fill with decode stalled; the third push must be refused.
        cyc(1, 32'hB1, 32'h100, 0, 0, 0);
        cyc(1, 32'hB2, 32'h104, 0, 0, 0);
        cyc(1, 32'hB3, 32'h108, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 1, 0);

        // Steady-state streaming at count=1, exercising pointer wrap.
        cyc(1, 32'hC0, 32'h200, 0, 0, 0);
        for (int i = 1; i <= 10; i++) cyc(1, 32'hC0 + i, 32'h200 + 4 * i, 0, 1, 0);
        cyc(0, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 1, 0);

        // Flush with a full queue and a concurrent push.
        cyc(1, 32'hD1, 32'h300, 0, 0, 0);
        cyc(1, 32'hD2, 32'h304, 0, 0, 0);
        cyc(1, 32'hDEAD, 32'h308, 1, 0, 0);
        cyc(0, 0, 0, 0, 1, 0);
        cyc(1, 32'hD3, 32'h30C, 0, 1, 0);
        cyc(0, 0, 0, 0, 1, 0);

        // Reset with two entries queued.
        cyc(1, 32'hE1, 32'h400, 0, 0, 0);
        cyc(1, 32'hE2, 32'h404, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 1, 0);

        for (int i = 0; i < 3000; i++)
            cyc($urandom_range(0, 3) != 0, $urandom, $urandom,
                $urandom_range(0, 15) == 0, $urandom_range(0, 2) != 0,
                $urandom_range(0, 63) == 0);

        cyc(0, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 1, 0);
        @(negedge clk);
        #3;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/if_id_queue.md
IF_ID_QUEUE -- requirements
Module: if_id_queue

Interface
REQ-001 SHALL have parameter: DEPTH, 2, number of entries; power of two, range 2..8.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on posedge clk.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: in_valid  input  1  fetch stage presents an instruction this cycle.
REQ-005 SHALL have port: in_instr  input  `INSTR_LEN  fetched instruction.
REQ-006 SHALL have port: in_pc  input  `WORD  PC of the fetched instruction.
REQ-007 SHALL have port: in_ready  output  1  queue can accept a push this cycle.
REQ-008 SHALL have port: flush  input  1  taken-branch kill (pc_src); discards all queued entries.
REQ-009 SHALL have port: out_valid  output  1  head entry valid for decode.
REQ-010 SHALL have port: out_instr  output  `INSTR_LEN  head instruction.
REQ-011 SHALL have port: out_pc  output  `WORD  head PC.
REQ-012 SHALL have port: out_ready  input  1  decode consumes head this cycle.

Function
REQ-013 SHALL push {in_instr,in_pc} at the tail when in_valid && in_ready && !flush.
REQ-014 SHALL pop the head when out_valid && out_ready && !flush.
REQ-015 SHALL drive in_ready = (count < DEPTH), from registered state only, with no combinational path from out_ready.
REQ-016 SHALL drive out_valid = (count != 0); out_instr/out_pc SHALL come from registered storage at the head pointer.
REQ-017 SHALL make an entry pushed in cycle N visible on out_* in cycle N+1 (latency 1).
REQ-018 SHALL, on simultaneous push and pop with 0 < count < DEPTH, leave count unchanged and advance both pointers.
REQ-019 SHALL wrap head and tail pointers modulo DEPTH; count SHALL be $clog2(DEPTH)+1 bits wide.
REQ-020 SHALL give flush priority over push and pop: next cycle count=0, head=tail=0, out_valid=0, and the same-cycle push is dropped.
REQ-021 SHALL hold out_instr/out_pc stable while out_valid && !out_ready.
REQ-022 SHALL drive out_instr = `NOP_INSTR and out_pc = 0 when out_valid=0.

Reset
REQ-023 SHALL, when reset=1 at a clock edge, clear count, head, and tail, and give out_valid=0, in_ready=1, out_instr=`NOP_INSTR, out_pc=0 in the next cycle.
REQ-024 SHALL give reset priority over flush, push, and pop; reset mid-operation SHALL discard all entries.

Configuration
REQ-025 SHALL, with IF_ID_PERF_CNT_EN defined, add output stall_cnt (16 bits): +1 each cycle in_valid && !in_ready, saturating at 16'hFFFF, cleared by reset only.
REQ-026 SHALL, without IF_ID_PERF_CNT_EN, omit the stall_cnt port and its logic entirely.

Structure
REQ-027 SHALL take `WORD (32), `INSTR_LEN (32), and `NOP_INSTR (32'h00000013) from the shared definitions include; no local redefinitions.
REQ-028 SHALL place entry storage in one sub-module, if_id_storage: a DEPTH x (`INSTR_LEN+`WORD) register array with write port (we, waddr, wdata) and asynchronous read port (raddr).

Verification
REQ-029 SHALL cover: reset, then push 32'hA in cycle 0 with in_pc=4 -> cycle 1: out_valid=1, out_instr=32'hA, out_pc=4.
REQ-030 SHALL cover: DEPTH=2, out_ready=0, push 3 entries -> in_ready=0 after 2nd push; 3rd not stored; (stall_cnt=1 if IF_ID_PERF_CNT_EN).
REQ-031 SHALL cover: count=1, in_valid=1 and out_ready=1 each cycle for 10 cycles -> count stays 1; outputs follow input order; pointers wrap correctly.
REQ-032 SHALL cover: count=2, flush=1 with in_valid=1 -> next cycle out_valid=0, count=0; the flushed-cycle instruction never appears.
REQ-033 SHALL cover: reset asserted with count=2 and flush=0 -> next cycle out_valid=0, in_ready=1, out_instr=32'h00000013, out_pc=0.
